calc_sequencer: RTL

Key-driven sequencer for the grid calculator. It consumes the 5-bit key codes produced by the cursor/grid front end, one per `key_valid` strobe. It assembles two hexadecimal operands and an operator, executes the operation on EXE, and holds the result for the 7-segment display path. It sits between the grid cursor (plus its press debouncer) and the display driver, and owns all calculator state.

---
 rtl/calc_sequencer.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/calc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : calc_sequencer
// Purpose  : Key-driven hex calculator core: operand entry, operator latch,
//            single-cycle execute and result hold for the display path.
// Revision : 1.0 - initial release
// ============================================================================
module calc_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_valid,
  input  logic [4:0]       key_val,
  output logic [WIDTH-1:0] display,
  output logic [1:0]       state,
  output logic [2:0]       op,
  output logic             result_valid,
  output logic             overflow
);

  localparam int NDIG = WIDTH / 4;
  localparam int DW   = $clog2(NDIG + 1);
  localparam logic [DW-1:0] MAX_DIG = DW'(NDIG);

  typedef enum logic [1:0] {
    S_ENTER_A = 2'b00,
    S_ENTER_B = 2'b01,
    S_RESULT  = 2'b10
  } state_e;

  localparam logic [2:0] OP_NONE = 3'd0;
  localparam logic [2:0] OP_ADD  = 3'd1;
  localparam logic [2:0] OP_SUB  = 3'd2;
  localparam logic [2:0] OP_MUL  = 3'd3;
  localparam logic [2:0] OP_AND  = 3'd4;
  localparam logic [2:0] OP_OR   = 3'd5;

  localparam logic [4:0] K_ADD = 5'h10;
  localparam logic [4:0] K_MUL = 5'h11;
  localparam logic [4:0] K_AND = 5'h12;
  localparam logic [4:0] K_EXE = 5'h13;
  localparam logic [4:0] K_SUB = 5'h14;
  localparam logic [4:0] K_OR  = 5'h15;
  localparam logic [4:0] K_CE  = 5'h16;
  localparam logic [4:0] K_CLR = 5'h17;

  state_e          state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [2:0]       op_q, op_d;
  logic [DW-1:0]    digits_q, digits_d;
  logic             rv_q, rv_d, ovf_q, ovf_d;

  logic [2:0]         w_key_op;
  logic               w_is_digit, w_is_op, w_room;
  logic [WIDTH-1:0]   w_digit_ext;
  logic [WIDTH:0]     w_sum, w_diff;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_exe_res;
  logic               w_exe_ovf;

  always_comb begin
    w_key_op = OP_NONE;
    case (key_val)
      K_ADD:   w_key_op = OP_ADD;
      K_SUB:   w_key_op = OP_SUB;
      K_MUL:   w_key_op = OP_MUL;
      K_AND:   w_key_op = OP_AND;
      K_OR:    w_key_op = OP_OR;
      default: w_key_op = OP_NONE;
    endcase
  end

  assign w_is_digit  = ~key_val[4];
  assign w_is_op     = (w_key_op != OP_NONE);
  assign w_room      = (digits_q < MAX_DIG);
  assign w_digit_ext = WIDTH'(key_val[3:0]);

  // Extra top bit carries the add carry-out / subtract borrow.
  assign w_sum  = {1'b0, a_q} + {1'b0, b_q};
  assign w_diff = {1'b0, a_q} - {1'b0, b_q};
  assign w_prod = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};

  always_comb begin
    w_exe_res = '0;
    w_exe_ovf = 1'b0;
    case (op_q)
      OP_ADD: begin w_exe_res = w_sum[WIDTH-1:0];  w_exe_ovf = w_sum[WIDTH];  end
      OP_SUB: begin w_exe_res = w_diff[WIDTH-1:0]; w_exe_ovf = w_diff[WIDTH]; end
      OP_MUL: begin w_exe_res = w_prod[WIDTH-1:0]; w_exe_ovf = |w_prod[2*WIDTH-1:WIDTH]; end
      OP_AND: w_exe_res = a_q & b_q;
      OP_OR:  w_exe_res = a_q | b_q;
      default: w_exe_res = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    op_d     = op_q;
    digits_d = digits_q;
    ovf_d    = ovf_q;
    rv_d     = 1'b0;
    if (key_valid) begin
      if (key_val == K_CLR) begin
        state_d  = S_ENTER_A;
        a_d      = '0;
        b_d      = '0;
        res_d    = '0;
        op_d     = OP_NONE;
        digits_d = '0;
        ovf_d    = 1'b0;
      end else begin
        case (state_q)
          S_ENTER_A: begin
            if (w_is_digit) begin
              if (w_room) begin
                a_d      = (a_q << 4) | w_digit_ext;
                digits_d = digits_q + DW'(1);
              end
            end else if (w_is_op) begin
              op_d     = w_key_op;
              b_d      = '0;
              digits_d = '0;
              state_d  = S_ENTER_B;
            end else if (key_val == K_CE) begin
              a_d      = '0;
              digits_d = '0;
            end
          end
          S_ENTER_B: begin
            if (w_is_digit) begin
              if (w_room) begin
                b_d      = (b_q << 4) | w_digit_ext;
                digits_d = digits_q + DW'(1);
              end
            end else if (w_is_op) begin
              // Operator may only be swapped before any B digit is typed.
              if (digits_q == '0) op_d = w_key_op;
            end else if (key_val == K_EXE) begin
              res_d   = w_exe_res;
              ovf_d   = w_exe_ovf;
              rv_d    = 1'b1;
              state_d = S_RESULT;
            end else if (key_val == K_CE) begin
              b_d      = '0;
              digits_d = '0;
            end
          end
          S_RESULT: begin
            if (w_is_digit) begin
              a_d      = w_digit_ext;
              digits_d = DW'(1);
              state_d  = S_ENTER_A;
            end else if (w_is_op) begin
              a_d      = res_q;
              op_d     = w_key_op;
              b_d      = '0;
              digits_d = '0;
              state_d  = S_ENTER_B;
            end else if (key_val == K_CE) begin
              state_d  = S_ENTER_A;
              a_d      = '0;
              b_d      = '0;
              res_d    = '0;
              op_d     = OP_NONE;
              digits_d = '0;
              ovf_d    = 1'b0;
            end
          end
          default: state_d = S_ENTER_A;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_ENTER_A;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      op_q     <= OP_NONE;
      digits_q <= '0;
      rv_q     <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      op_q     <= op_d;
      digits_q <= digits_d;
      rv_q     <= rv_d;
      ovf_q    <= ovf_d;
    end
  end

  always_comb begin
    display = a_q;
    case (state_q)
      S_ENTER_B: display = (digits_q != '0) ? b_q : a_q;
      S_RESULT:  display = res_q;
      default:   display = a_q;
    endcase
  end

  assign state        = state_q;
  assign op           = op_q;
  assign result_valid = rv_q;
  assign overflow     = ovf_q;

endmodule
`default_nettype wire
